// File: rtl/display_adapter_pkg.sv
// Shared definitions for the frame-buffer display path: scheduler states,
// one-hot mux select constants and default frame geometry.
package display_adapter_pkg;

   localparam int unsigned DEFAULT_FRAME_PIXELS = 76800;

   // Select constants ordered {SelBuf0, SelBlank, SelBuf1}
   localparam logic [2:0] SEL_BUF0  = 3'b100;
   localparam logic [2:0] SEL_BLANK = 3'b010;
   localparam logic [2:0] SEL_BUF1  = 3'b001;

   // State codes equal the select patterns so the mux lines come straight off the state register
   typedef enum logic [2:0] {
      BLANK = SEL_BLANK,
      SHOW0 = SEL_BUF0,
      SHOW1 = SEL_BUF1
   } schedState_t;

   function automatic schedState_t showState(input logic bufSel);
      return bufSel ? SHOW1 : SHOW0;
   endfunction

endpackage

// File: rtl/pixel_addr_counter.sv
// Wrapping pixel address counter: advances on Enable, wraps to 0 after COUNT-1,
// and flags the terminal count so the caller can detect frame boundaries.
module pixel_addr_counter
   import display_adapter_pkg::*;
#(
   parameter int unsigned COUNT = DEFAULT_FRAME_PIXELS,
   parameter int unsigned WIDTH = 17
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic             Enable,
   output logic [WIDTH-1:0] Count,
   output logic             Terminal
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(COUNT - 1);

   assign Terminal = (Count == LAST);

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         Count <= '0;
      end else if (Enable) begin
         Count <= Terminal ? '0 : Count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Ping-pong front/back buffer scheduler with stale-frame blanking.
// Optional ForceBlank input enabled by defining FRAME_SCHED_FORCE_BLANK_EN.
module frame_buffer_scheduler
   import display_adapter_pkg::*;
#(
   parameter int unsigned FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
   parameter int unsigned ADDR_W       = 17,
   parameter int unsigned STALE_LIMIT  = 8,
   parameter int unsigned STALE_W      = 4
) (
   input  logic              Clk,
   input  logic              nReset,
   input  logic              PixelReq,
   input  logic              WrDone,
`ifdef FRAME_SCHED_FORCE_BLANK_EN
   input  logic              ForceBlank,
`endif
   output logic              WrBufSel,
   output logic              WrReady,
   output logic [ADDR_W-1:0] RdAddr,
   output logic              SelBuf0,
   output logic              SelBlank,
   output logic              SelBuf1,
   output logic              FrameSync,
   output logic              Overrun
);

   schedState_t        state, stateNext;
   logic               pending, pendingNext;
   logic [STALE_W-1:0] stale, staleNext, staleInc;
   logic               wrBufSel, wrBufSelNext;
   logic               addrTerminal;
   logic               boundary;
   logic               forceBlank;

`ifdef FRAME_SCHED_FORCE_BLANK_EN
   assign forceBlank = ForceBlank;
`else
   assign forceBlank = 1'b0;
`endif

   pixel_addr_counter #(
      .COUNT (FRAME_PIXELS),
      .WIDTH (ADDR_W)
   ) uAddrCounter (
      .Clk      (Clk),
      .nReset   (nReset),
      .Enable   (PixelReq),
      .Count    (RdAddr),
      .Terminal (addrTerminal)
   );

   assign boundary = PixelReq & addrTerminal;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state     <= BLANK;
         pending   <= 1'b0;
         stale     <= '0;
         wrBufSel  <= 1'b0;
         FrameSync <= 1'b0;
         Overrun   <= 1'b0;
      end else begin
         state     <= stateNext;
         pending   <= pendingNext;
         stale     <= staleNext;
         wrBufSel  <= wrBufSelNext;
         FrameSync <= boundary;
         Overrun   <= WrDone & pending;
      end
   end

   // A WrDone landing on the boundary only arms pending; the swap below looks at the old pending
   always_comb begin
      stateNext    = state;
      pendingNext  = pending;
      staleNext    = stale;
      wrBufSelNext = wrBufSel;
      staleInc     = stale + STALE_W'(1);

      if (WrDone && !pending) begin
         pendingNext = 1'b1;
      end

      if (boundary) begin
         if (forceBlank) begin
            stateNext = BLANK;
            staleNext = '0;
         end else if (pending) begin
            stateNext    = showState(wrBufSel);
            wrBufSelNext = ~wrBufSel;
            pendingNext  = 1'b0;
            staleNext    = '0;
         end else if (state != BLANK) begin
            if ((STALE_LIMIT != 0) && (staleInc == STALE_W'(STALE_LIMIT))) begin
               stateNext = BLANK;
               staleNext = '0;
            end else begin
               staleNext = staleInc;
            end
         end
      end
   end

   assign {SelBuf0, SelBlank, SelBuf1} = state;
   assign WrBufSel = wrBufSel;
   assign WrReady  = ~pending;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Self-checking bench for frame_buffer_scheduler: directed scenarios plus random
// traffic against a behavioural frame-level model.
module tb_frame_buffer_scheduler;

   localparam int FP    = 16;
   localparam int LIMIT = 2;

   logic       Clk;
   logic       nReset;
   logic       PixelReq;
   logic       WrDone;
`ifdef FRAME_SCHED_FORCE_BLANK_EN
   logic       ForceBlank;
`endif
   logic       WrBufSel;
   logic       WrReady;
   logic [4:0] RdAddr;
   logic       SelBuf0;
   logic       SelBlank;
   logic       SelBuf1;
   logic       FrameSync;
   logic       Overrun;

   frame_buffer_scheduler #(
      .FRAME_PIXELS (FP),
      .ADDR_W       (5),
      .STALE_LIMIT  (LIMIT),
      .STALE_W      (4)
   ) dut (
      .Clk       (Clk),
      .nReset    (nReset),
      .PixelReq  (PixelReq),
      .WrDone    (WrDone),
`ifdef FRAME_SCHED_FORCE_BLANK_EN
      .ForceBlank(ForceBlank),
`endif
      .WrBufSel  (WrBufSel),
      .WrReady   (WrReady),
      .RdAddr    (RdAddr),
      .SelBuf0   (SelBuf0),
      .SelBlank  (SelBlank),
      .SelBuf1   (SelBuf1),
      .FrameSync (FrameSync),
      .Overrun   (Overrun)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int nChecks = 0;
   int nErrors = 0;
   bit chkEn   = 0;

   // Frame-level model: mShow is -1 for blank, else the buffer on screen
   int mAddr, mShow, mStale;
   bit mPend, mWrBuf, mSync, mOvr;

   task automatic check(input string name, input longint act, input longint exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelReset();
      mAddr = 0; mShow = -1; mStale = 0;
      mPend = 0; mWrBuf = 0; mSync = 0; mOvr = 0;
   endfunction

   function automatic void modelStep(input bit pr, input bit wd);
      bit boundary, fb, pendNext;
      if (!nReset) begin
         modelReset();
         return;
      end
`ifdef FRAME_SCHED_FORCE_BLANK_EN
      fb = ForceBlank;
`else
      fb = 0;
`endif
      boundary = pr && (mAddr == FP - 1);
      mSync    = boundary;
      mOvr     = wd && mPend;
      pendNext = mPend || wd;
      if (boundary) begin
         if (fb) begin
            mShow = -1; mStale = 0;
         end else if (mPend) begin
            mShow    = mWrBuf;
            mWrBuf   = !mWrBuf;
            pendNext = 0;
            mStale   = 0;
         end else if (mShow >= 0) begin
            mStale++;
            if (LIMIT != 0 && mStale == LIMIT) begin
               mShow = -1; mStale = 0;
            end
         end
      end
      mPend = pendNext;
      if (pr) mAddr = (mAddr + 1) % FP;
   endfunction

   always @(negedge Clk) begin
      if (chkEn) begin
         check("SelBuf0",   SelBuf0,   mShow == 0);
         check("SelBlank",  SelBlank,  mShow < 0);
         check("SelBuf1",   SelBuf1,   mShow == 1);
         check("oneHot",    $countones({SelBuf0, SelBlank, SelBuf1}), 1);
         check("RdAddr",    RdAddr,    mAddr);
         check("WrBufSel",  WrBufSel,  mWrBuf);
         check("WrReady",   WrReady,   !mPend);
         check("FrameSync", FrameSync, mSync);
         check("Overrun",   Overrun,   mOvr);
      end
   end

   task automatic tick(input bit pr, input bit wd);
      PixelReq = pr;
      WrDone   = wd;
      @(posedge Clk);
      modelStep(pr, wd);
      #1;
   endtask

   task automatic runToSync();
      bit seen = 0;
      for (int i = 0; i < 2 * FP + 4; i++) begin
         tick(1, 0);
         if (FrameSync) begin
            seen = 1;
            break;
         end
      end
      if (!seen) check("syncTimeout", 0, 1);
   endtask

   task automatic advanceTo(input int addr);
      bit hit = 0;
      for (int i = 0; i < 2 * FP + 4; i++) begin
         if (RdAddr == addr) begin
            hit = 1;
            break;
         end
         tick(1, 0);
      end
      if (!hit) check("addrTimeout", RdAddr, addr);
   endtask

   task automatic doReset();
      nReset = 0;
      #1;
      modelReset();
      tick(0, 0);
      tick(0, 0);
      nReset = 1;
   endtask

   initial begin
      int syncs, firstSync, secondSync;
      nReset   = 1;
      PixelReq = 0;
      WrDone   = 0;
`ifdef FRAME_SCHED_FORCE_BLANK_EN
      ForceBlank = 0;
`endif
      #1;
      nReset = 0;
      modelReset();
      chkEn = 1;
      tick(0, 0);
      tick(0, 0);
      nReset = 1;

      check("rstSelBlank", SelBlank, 1);
      check("rstRdAddr",   RdAddr,   0);
      check("rstWrReady",  WrReady,  1);
      check("rstWrBufSel", WrBufSel, 0);

      // Idle: 40 pixels, no frames produced
      syncs = 0; firstSync = 0; secondSync = 0;
      for (int i = 1; i <= 40; i++) begin
         tick(1, 0);
         if (FrameSync) begin
            syncs++;
            if (syncs == 1) firstSync = i;
            if (syncs == 2) secondSync = i;
         end
      end
      check("idleSyncCount", syncs, 2);
      check("idleSync1",     firstSync, 16);
      check("idleSync2",     secondSync, 32);
      check("idleBlank",     SelBlank, 1);

      // First frame and swap
      advanceTo(5);
      tick(1, 1);
      check("wrReadyFalls", WrReady, 0);
      runToSync();
      check("swap1Buf0",     SelBuf0,  1);
      check("swap1WrBufSel", WrBufSel, 1);
      check("swap1WrReady",  WrReady,  1);
      tick(1, 1);
      runToSync();
      check("swap2Buf1",     SelBuf1,  1);
      check("swap2WrBufSel", WrBufSel, 0);

      // Overrun: second WrDone inside the same frame
      tick(1, 1);
      tick(1, 0);
      tick(1, 1);
      check("overrunPulse", Overrun, 1);
      tick(1, 0);
      check("overrunEnds", Overrun, 0);
      runToSync();
      check("ovrSwapBuf0",  SelBuf0,  1);
      check("ovrWrBufSel",  WrBufSel, 1);
      check("ovrWrReady",   WrReady,  1);

      // Stale fallback from SHOW0
      runToSync();
      check("stale1Buf0", SelBuf0, 1);
      runToSync();
      check("stale2Blank", SelBlank, 1);
      check("staleKeepsWrBuf", WrBufSel, 1);
      tick(1, 1);
      runToSync();
      check("afterBlankBuf1", SelBuf1, 1);
      check("afterBlankWrBuf", WrBufSel, 0);

      // WrDone on the boundary cycle: no bypass
      advanceTo(FP - 1);
      tick(1, 1);
      check("simulSync",    FrameSync, 1);
      check("simulNoSwap",  SelBuf1,   1);
      check("simulPending", WrReady,   0);
      runToSync();
      check("simulLateSwap", SelBuf0, 1);
      check("simulWrBufSel", WrBufSel, 1);

      // Reset mid-frame with a pending frame
      tick(1, 1);
      advanceTo(9);
      check("preRstPending", WrReady, 0);
      nReset = 0;
      #1;
      modelReset();
      check("midRstBlank",   SelBlank, 1);
      check("midRstBuf0",    SelBuf0,  0);
      check("midRstAddr",    RdAddr,   0);
      check("midRstWrReady", WrReady,  1);
      tick(0, 0);
      tick(0, 0);
      nReset = 1;

`ifdef FRAME_SCHED_FORCE_BLANK_EN
      tick(1, 1);
      runToSync();
      tick(1, 1);
      runToSync();
      check("fbInShow1", SelBuf1, 1);
      ForceBlank = 1;
      tick(1, 1);
      runToSync();
      check("fbBlank",   SelBlank, 1);
      check("fbPending", WrReady,  0);
      ForceBlank = 0;
      runToSync();
      check("fbResumeBuf0", SelBuf0, 1);
      check("fbWrReady",    WrReady, 1);
`endif

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            doReset();
         end else begin
`ifdef FRAME_SCHED_FORCE_BLANK_EN
            if ($urandom_range(0, 99) == 0) ForceBlank = ~ForceBlank;
`endif
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
         end
      end

      chkEn = 0;
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
